// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS core definitions: opcode field location, memory
//                opcodes, CP0 exception codes and the EX/MEM register bundle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    // Location of the primary opcode inside an instruction word
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;

    // Memory-access opcodes
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    // CP0 ExcCode values (Cause[6:2])
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Kind of memory access an instruction performs
    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_kind_t;

    // Everything the MEM stage receives from EX
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [31:0] ao;
        logic [31:0] mdo;
        logic [31:0] rt;
        logic        bd;
        logic        valid;
        logic [4:0]  excode;
    } exmem_bundle_t;

    // Extract the primary opcode of an instruction
    function automatic logic [5:0] op_of(input logic [31:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/exmem_reg_if.sv
// ============================================================================
//  Module      : exmem_reg_if
//  Description : EX-side inputs, stage control and MEM-side outputs of the
//                EX/MEM pipeline register.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface exmem_reg_if;

    // Stage control
    logic        en;
    logic        flush;

    // EX side
    logic [31:0] IR_E;
    logic [31:0] PC_E;
    logic [31:0] PC8_E;
    logic [31:0] ALU;
    logic [31:0] Mult_Div;
    logic [31:0] RT_E;
    logic        ov_E;
    logic        BD_E;
    logic [6:2]  excode_E;

    // MEM side
    logic [31:0] IR_M;
    logic [31:0] PC_M;
    logic [31:0] PC8_M;
    logic [31:0] AO_M;
    logic [31:0] MDO_M;
    logic [31:0] RT_M;
    logic        BD_M;
    logic        valid_M;
    logic [6:2]  excode_M;

    // EX stage / hazard unit side
    modport master (
        output en, flush, IR_E, PC_E, PC8_E, ALU, Mult_Div, RT_E, ov_E, BD_E, excode_E,
        input  IR_M, PC_M, PC8_M, AO_M, MDO_M, RT_M, BD_M, valid_M, excode_M
    );

    // Pipeline register side
    modport slave (
        input  en, flush, IR_E, PC_E, PC8_E, ALU, Mult_Div, RT_E, ov_E, BD_E, excode_E,
        output IR_M, PC_M, PC8_M, AO_M, MDO_M, RT_M, BD_M, valid_M, excode_M
    );

endinterface

`default_nettype wire

// File: rtl/exmem_addr_chk.sv
// ============================================================================
//  Module      : exmem_addr_chk
//  Description : Combinational address / overflow exception check for an
//                instruction leaving EX. Produces the ExcCode to carry into MEM.
//                Optional build macro EXMEM_DEV_SUBWORD_CHK_EN makes device
//                windows word-only (sub-word loads/stores to them fault).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module exmem_addr_chk
    import mips_pkg::*;
#(
    parameter logic [31:0] DM_TOP      = 32'h0000_2fff,
    parameter int          NUM_DEV     = 2,
    parameter logic [31:0] DEV_BASE    = 32'h0000_7f00,
    parameter logic [31:0] DEV_STRIDE  = 32'h0000_0010,
    parameter int          DEV_SPAN    = 12,
    parameter int          DEV_WR_SPAN = 8
) (
    input  wire logic [31:0] ir,
    input  wire logic [31:0] addr,
    input  wire logic        ov,
    input  wire logic [6:2]  excode_in,
    output logic      [6:2]  next_excode
);

    // Window math is done 4 bits wider so base + span can never wrap
    logic [35:0]        w_addr_wide;
    logic [NUM_DEV-1:0] w_win_rd;
    logic [NUM_DEV-1:0] w_win_wr;
    logic [5:0]         w_op;
    logic               w_unused_ir;

    assign w_addr_wide = {4'b0000, addr};
    assign w_op        = op_of(ir);
    assign w_unused_ir = ^ir[OP_LSB-1:0];

    for (genvar i = 0; i < NUM_DEV; i++) begin : g_win
        localparam logic [35:0] WIN_BASE = 36'(DEV_BASE) + 36'(i) * 36'(DEV_STRIDE);
        assign w_win_rd[i] = (w_addr_wide >= WIN_BASE) &&
                             (w_addr_wide <  WIN_BASE + 36'(DEV_SPAN));
        assign w_win_wr[i] = (w_addr_wide >= WIN_BASE) &&
                             (w_addr_wide <  WIN_BASE + 36'(DEV_WR_SPAN));
    end

    mem_kind_t w_kind;
    logic      w_misalign;
    logic      w_subword;
    logic      w_in_dm;
    logic      w_dev_rd;
    logic      w_dev_wr;
    logic      w_load_bad;
    logic      w_store_bad;

    // Decode the access, evaluate the address map and pick the exception
    always_comb begin
        w_kind     = MEM_NONE;
        w_misalign = 1'b0;
        w_subword  = 1'b0;
        case (w_op)
            OP_LW:         begin w_kind = MEM_LOAD;  w_misalign = (addr[1:0] != 2'b00); end
            OP_LH, OP_LHU: begin w_kind = MEM_LOAD;  w_misalign = addr[0]; w_subword = 1'b1; end
            OP_LB, OP_LBU: begin w_kind = MEM_LOAD;  w_subword  = 1'b1; end
            OP_SW:         begin w_kind = MEM_STORE; w_misalign = (addr[1:0] != 2'b00); end
            OP_SH:         begin w_kind = MEM_STORE; w_misalign = addr[0]; w_subword = 1'b1; end
            OP_SB:         begin w_kind = MEM_STORE; w_subword  = 1'b1; end
            default:       begin w_kind = MEM_NONE; end
        endcase

        w_in_dm  = (addr <= DM_TOP);
        w_dev_rd = |w_win_rd;
        w_dev_wr = |w_win_wr;

        // Stores into the read-only tail of a window (count register) fault
        w_load_bad  = w_misalign || ov || !(w_in_dm || w_dev_rd);
        w_store_bad = w_misalign || ov || !(w_in_dm || w_dev_wr);
`ifdef EXMEM_DEV_SUBWORD_CHK_EN
        if (w_subword && w_dev_rd) begin
            w_load_bad  = 1'b1;
            w_store_bad = 1'b1;
        end
`else
        w_load_bad  = w_load_bad  || (w_subword && 1'b0);
`endif

        if (excode_in != EXC_NONE) begin
            next_excode = excode_in;
        end else if (w_kind == MEM_LOAD && w_load_bad) begin
            next_excode = EXC_ADEL;
        end else if (w_kind == MEM_STORE && w_store_bad) begin
            next_excode = EXC_ADES;
        end else if (w_kind == MEM_NONE && ov) begin
            next_excode = EXC_OV;
        end else begin
            next_excode = EXC_NONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/exmem_reg.sv
// ============================================================================
//  Module      : exmem_reg
//  Description : EX/MEM pipeline register with stall, flush-to-bubble and a
//                registered address / overflow exception code.
//                Optional build macro EXMEM_DEV_SUBWORD_CHK_EN (see
//                exmem_addr_chk) makes device windows word-only.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module exmem_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] DM_TOP      = 32'h0000_2fff,
    parameter int          NUM_DEV     = 2,
    parameter logic [31:0] DEV_BASE    = 32'h0000_7f00,
    parameter logic [31:0] DEV_STRIDE  = 32'h0000_0010,
    parameter int          DEV_SPAN    = 12,
    parameter int          DEV_WR_SPAN = 8
) (
    input  wire logic  clk,
    input  wire logic  reset,
    exmem_reg_if.slave bus
);

    logic [6:2]    w_next_excode;
    exmem_bundle_t r_m;

    exmem_addr_chk #(
        .DM_TOP      (DM_TOP),
        .NUM_DEV     (NUM_DEV),
        .DEV_BASE    (DEV_BASE),
        .DEV_STRIDE  (DEV_STRIDE),
        .DEV_SPAN    (DEV_SPAN),
        .DEV_WR_SPAN (DEV_WR_SPAN)
    ) u_addr_chk (
        .ir          (bus.IR_E),
        .addr        (bus.ALU),
        .ov          (bus.ov_E),
        .excode_in   (bus.excode_E),
        .next_excode (w_next_excode)
    );

    // Register bank: reset beats flush beats advance; otherwise hold.
    // A bubble keeps PC so CP0 still has a restart PC for interrupts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m <= '0;
        end else if (bus.flush) begin
            r_m    <= '0;
            r_m.pc <= bus.PC_E;
        end else if (bus.en) begin
            r_m.ir     <= bus.IR_E;
            r_m.pc     <= bus.PC_E;
            r_m.pc8    <= bus.PC8_E;
            r_m.ao     <= bus.ALU;
            r_m.mdo    <= bus.Mult_Div;
            r_m.rt     <= bus.RT_E;
            r_m.bd     <= bus.BD_E;
            r_m.valid  <= 1'b1;
            r_m.excode <= w_next_excode;
        end
    end

    assign bus.IR_M     = r_m.ir;
    assign bus.PC_M     = r_m.pc;
    assign bus.PC8_M    = r_m.pc8;
    assign bus.AO_M     = r_m.ao;
    assign bus.MDO_M    = r_m.mdo;
    assign bus.RT_M     = r_m.rt;
    assign bus.BD_M     = r_m.bd;
    assign bus.valid_M  = r_m.valid;
    assign bus.excode_M = r_m.excode;

endmodule

`default_nettype wire

// File: tb/tb_exmem_reg.sv
// ============================================================================
//  Module      : tb_exmem_reg
//  Description : Scoreboard bench for exmem_reg. Two instances (NUM_DEV=2 and
//                NUM_DEV=1) share stimulus; a reference model predicts each
//                register's next contents from the address map rules.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_exmem_reg;
    import mips_pkg::*;

    localparam logic [31:0] DM_TOP      = 32'h0000_2fff;
    localparam logic [31:0] DEV_BASE    = 32'h0000_7f00;
    localparam logic [31:0] DEV_STRIDE  = 32'h0000_0010;
    localparam int          DEV_SPAN    = 12;
    localparam int          DEV_WR_SPAN = 8;

`ifdef EXMEM_DEV_SUBWORD_CHK_EN
    localparam int LB_DEV_EXP = 4;
    localparam int SB_DEV_EXP = 5;
`else
    localparam int LB_DEV_EXP = 0;
    localparam int SB_DEV_EXP = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    exmem_reg_if bus0 ();
    exmem_reg_if bus1 ();

    exmem_reg #(.DM_TOP(DM_TOP), .NUM_DEV(2), .DEV_BASE(DEV_BASE), .DEV_STRIDE(DEV_STRIDE),
                .DEV_SPAN(DEV_SPAN), .DEV_WR_SPAN(DEV_WR_SPAN))
        dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

    exmem_reg #(.DM_TOP(DM_TOP), .NUM_DEV(1), .DEV_BASE(DEV_BASE), .DEV_STRIDE(DEV_STRIDE),
                .DEV_SPAN(DEV_SPAN), .DEV_WR_SPAN(DEV_WR_SPAN))
        dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    typedef struct {
        logic [31:0] ir, pc, pc8, ao, mdo, rt;
        logic        bd, valid;
        logic [4:0]  exc;
        string       tag;
    } m_t;

    m_t q0[$];
    m_t q1[$];
    m_t st0, st1;
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    function automatic logic [4:0] ref_excode(input logic [5:0] op, input logic [31:0] addr,
                                              input bit ov, input logic [4:0] up, input int nd);
        bit     is_ld, is_st, bad, dm, dev_ok;
        int     size, wnd;
        longint a, b, off;
        if (up != 0) return up;
        is_ld = (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LB) || (op == OP_LBU);
        is_st = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
        if (!is_ld && !is_st) return ov ? 5'd12 : 5'd0;
        size = (op == OP_LW || op == OP_SW) ? 4 :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
        a    = longint'(addr);
        bad  = ov || ((a % size) != 0);
        dm   = (a <= longint'(DM_TOP));
        wnd  = -1;
        off  = 0;
        for (int i = 0; i < nd; i++) begin
            b = longint'(DEV_BASE) + longint'(i) * longint'(DEV_STRIDE);
            if (a >= b && (a - b) < DEV_SPAN) begin
                wnd = i;
                off = a - b;
            end
        end
        dev_ok = (wnd >= 0) && (is_ld || off < DEV_WR_SPAN);
`ifdef EXMEM_DEV_SUBWORD_CHK_EN
        if (size < 4 && wnd >= 0) bad = 1'b1;
`endif
        if (!(dm || dev_ok)) bad = 1'b1;
        if (!bad) return 5'd0;
        return is_ld ? 5'd4 : 5'd5;
    endfunction

    function automatic m_t model_next(input m_t s, input int nd, input int xo, input string tag);
        m_t n;
        n = s;
        if (reset) begin
            n = '{ir:0, pc:0, pc8:0, ao:0, mdo:0, rt:0, bd:0, valid:0, exc:0, tag:""};
        end else if (bus0.flush) begin
            n = '{ir:0, pc:bus0.PC_E, pc8:0, ao:0, mdo:0, rt:0, bd:0, valid:0, exc:0, tag:""};
        end else if (bus0.en) begin
            n.ir    = bus0.IR_E;
            n.pc    = bus0.PC_E;
            n.pc8   = bus0.PC8_E;
            n.ao    = bus0.ALU;
            n.mdo   = bus0.Mult_Div;
            n.rt    = bus0.RT_E;
            n.bd    = bus0.BD_E;
            n.valid = 1'b1;
            n.exc   = (xo >= 0) ? 5'(xo)
                                : ref_excode(bus0.IR_E[31:26], bus0.ALU, bus0.ov_E, bus0.excode_E, nd);
        end
        n.tag = tag;
        return n;
    endfunction

    // ---------------- stimulus ----------------
    // x0/x1: fixed expected excode for the NUM_DEV=2 / NUM_DEV=1 instance, -1 = use model
    task automatic step(input string tag, input bit rst, input bit en, input bit fl,
                        input logic [5:0] op, input logic [31:0] alu, input bit ov,
                        input logic [4:0] up, input int x0, input int x1);
        logic [31:0] r;
        @(negedge clk);
        r = $urandom();
        reset         = rst;
        bus0.en       = en;        bus1.en       = en;
        bus0.flush    = fl;        bus1.flush    = fl;
        bus0.IR_E     = {op, r[25:0]};
        bus1.IR_E     = bus0.IR_E;
        bus0.PC_E     = $urandom() & 32'hffff_fffc;  bus1.PC_E     = bus0.PC_E;
        bus0.PC8_E    = bus0.PC_E + 32'd8;           bus1.PC8_E    = bus0.PC8_E;
        bus0.ALU      = alu;                         bus1.ALU      = alu;
        bus0.Mult_Div = $urandom();                  bus1.Mult_Div = bus0.Mult_Div;
        bus0.RT_E     = $urandom();                  bus1.RT_E     = bus0.RT_E;
        bus0.ov_E     = ov;                          bus1.ov_E     = ov;
        bus0.BD_E     = r[31];                       bus1.BD_E     = r[31];
        bus0.excode_E = up;                          bus1.excode_E = up;
        st0 = model_next(st0, 2, x0, tag);
        st1 = model_next(st1, 1, x1, tag);
        q0.push_back(st0);
        q1.push_back(st1);
    endtask

    // ---------------- monitor ----------------
    task automatic compare(input string who, input m_t a, input m_t e);
        checks++;
        if (a.ir !== e.ir || a.pc !== e.pc || a.pc8 !== e.pc8 || a.ao !== e.ao ||
            a.mdo !== e.mdo || a.rt !== e.rt || a.bd !== e.bd || a.valid !== e.valid ||
            a.exc !== e.exc) begin
            errors++;
            $display("FAIL %s %s: got ir=%h pc=%h pc8=%h ao=%h mdo=%h rt=%h bd=%b v=%b exc=%0d want ir=%h pc=%h pc8=%h ao=%h mdo=%h rt=%h bd=%b v=%b exc=%0d",
                     who, e.tag, a.ir, a.pc, a.pc8, a.ao, a.mdo, a.rt, a.bd, a.valid, a.exc,
                     e.ir, e.pc, e.pc8, e.ao, e.mdo, e.rt, e.bd, e.valid, e.exc);
        end
    endtask

    // Every edge presents a register value; compare it with the oldest prediction
    initial begin
        m_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                a = '{ir:bus0.IR_M, pc:bus0.PC_M, pc8:bus0.PC8_M, ao:bus0.AO_M, mdo:bus0.MDO_M,
                      rt:bus0.RT_M, bd:bus0.BD_M, valid:bus0.valid_M, exc:bus0.excode_M, tag:""};
                compare("dev2", a, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = '{ir:bus1.IR_M, pc:bus1.PC_M, pc8:bus1.PC8_M, ao:bus1.AO_M, mdo:bus1.MDO_M,
                      rt:bus1.RT_M, bd:bus1.BD_M, valid:bus1.valid_M, exc:bus1.excode_M, tag:""};
                compare("dev1", a, e);
            end
        end
    end

    // ---------------- test sequence ----------------
    logic [5:0] ops [10] = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH, 6'h00, 6'h08};

    initial begin
        logic [31:0] addr;
        logic [4:0]  up;
        st0 = '{ir:0, pc:0, pc8:0, ao:0, mdo:0, rt:0, bd:0, valid:0, exc:0, tag:""};
        st1 = st0;
        bus0.en = 1'b0; bus0.flush = 1'b0; bus1.en = 1'b0; bus1.flush = 1'b0;

        step("reset_a", 1, 0, 0, 6'h00, 32'h0, 0, 0, 0, 0);
        step("reset_b", 1, 1, 0, OP_LW, 32'h1, 0, 0, 0, 0);

        step("lw_mis",   0, 1, 0, OP_LW,  32'h0000_0002, 0, 0,  4,  4);
        step("sw_mis",   0, 1, 0, OP_SW,  32'h0000_0002, 0, 0,  5,  5);
        step("lh_ok",    0, 1, 0, OP_LH,  32'h0000_0002, 0, 0,  0,  0);
        step("sw_cnt",   0, 1, 0, OP_SW,  32'h0000_7f08, 0, 0,  5,  5);
        step("lw_cnt",   0, 1, 0, OP_LW,  32'h0000_7f08, 0, 0,  0,  0);
        step("lw_span",  0, 1, 0, OP_LW,  32'h0000_7f0c, 0, 0,  4,  4);
        step("sw_win1",  0, 1, 0, OP_SW,  32'h0000_7f14, 0, 0,  0,  5);
        step("lw_win1",  0, 1, 0, OP_LW,  32'h0000_7f10, 0, 0,  0,  4);
        step("lw_w1end", 0, 1, 0, OP_LW,  32'h0000_7f1c, 0, 0,  4,  4);
        step("lb_dev",   0, 1, 0, OP_LB,  32'h0000_7f01, 0, 0, LB_DEV_EXP, LB_DEV_EXP);
        step("sb_dev",   0, 1, 0, OP_SB,  32'h0000_7f07, 0, 0, SB_DEV_EXP, SB_DEV_EXP);
        step("sb_cnt",   0, 1, 0, OP_SB,  32'h0000_7f08, 0, 0,  5,  5);
        step("lbu_past", 0, 1, 0, OP_LBU, 32'h0000_3000, 0, 0,  4,  4);
        step("lbu_top",  0, 1, 0, OP_LBU, 32'h0000_2fff, 0, 0,  0,  0);
        step("sw_top",   0, 1, 0, OP_SW,  32'h0000_2ffc, 0, 0,  0,  0);
        step("lw_wrap",  0, 1, 0, OP_LW,  32'hffff_fffc, 0, 0,  4,  4);
        step("add_ov",   0, 1, 0, 6'h00,  32'h8000_0000, 1, 0, 12, 12);
        step("up_wins",  0, 1, 0, 6'h00,  32'h8000_0000, 1, 10, 10, 10);
        step("lw_ov",    0, 1, 0, OP_LW,  32'h0000_0000, 1, 0,  4,  4);
        step("add_ok",   0, 1, 0, 6'h00,  32'h1234_5678, 0, 0,  0,  0);
        step("stall_1",  0, 0, 0, OP_SW,  32'h0000_0001, 1, 0, -1, -1);
        step("stall_2",  0, 0, 0, OP_LW,  32'h0000_0003, 0, 9, -1, -1);
        step("stall_3",  0, 0, 0, 6'h00,  32'h0000_0000, 1, 0, -1, -1);
        step("flush_st", 0, 0, 1, OP_LW,  32'h0000_0002, 0, 0,  0,  0);
        step("refill",   0, 1, 0, OP_LW,  32'h0000_0010, 0, 0,  0,  0);
        step("rst_mid",  1, 1, 1, OP_LW,  32'h0000_0002, 0, 0,  0,  0);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0:       addr = $urandom();
                1:       addr = $urandom_range(0, 32'h3003);
                2:       addr = DEV_BASE + $urandom_range(0, 32'h2f);
                3:       addr = DM_TOP - 32'd3 + $urandom_range(0, 7);
                default: addr = 32'hffff_ff00 + $urandom_range(0, 32'hff);
            endcase
            up = ($urandom_range(0, 7) == 0) ? 5'(8 + $urandom_range(0, 2)) : 5'd0;
            step("random", ($urandom_range(0, 49) == 0), ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 8), ops[$urandom_range(0, 9)], addr,
                 ($urandom_range(0, 7) == 0), up, -1, -1);
        end

        // Let the monitor drain; a stuck queue is itself a failure
        for (int w = 0; w < 10 && (q0.size() > 0 || q1.size() > 0); w++) @(posedge clk);
        #2;
        if (q0.size() > 0 || q1.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d/%0d pending want 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
